count_event_monitor: RTL and testbench
======================================

// Module: count_event_monitor
// PURPOSE
//  Downstream consumer of the AXI counter IP's count_out bus.
//  - Samples the 8-bit count every aclk; detects wrap-up, wrap-down and threshold-match events.
//  - Queues timestamped event records in a small FIFO, drained over a valid/ready stream.
//  - Sits between counter IP and the event/interrupt logic in the same block design.
// PARAMETERS
//  CNT_W     8   width of count_in and recorded count
//  TS_W      16  width of free-running timestamp counter
//  DEPTH     4   FIFO entries (power of 2, >=2)
//  IRQ_LEVEL 1   FIFO occupancy at/above which irq asserts (1..DEPTH)
// PORTS
//  aclk           in   1              system clock, rising edge
//  aresetn        in   1              async active-low reset
//  count_in       in   CNT_W          count_out of counter IP
//  mon_en         in   1              monitor enable
//  threshold      in   CNT_W          match value
//  ev_valid       out  1              record available at FIFO head
//  ev_ready       in   1              consumer accepts head record
//  ev_data        out  3+CNT_W+TS_W   {match,wrap_up,wrap_dn, count, timestamp}
//  ev_level       out  clog2(DEPTH)+1 FIFO occupancy
//  drop_cnt       out  8              events dropped on full, saturates at 0xFF
//  irq            out  1              event-pending interrupt, level
// BEHAVIOUR
//  Reset (aresetn=0, async): all outputs 0; FIFO empty; ts=0; cur_q/prev_q=0; sample-valid bits clear.
//  Timestamp ts: +1 every cycle regardless of mon_en; wraps 2^TS_W-1 -> 0.
//  Sampling, each edge with mon_en=1:
//  - cur_q<=count_in, prev_q<=cur_q.
//  - vld0<=1, vld1<=vld0.
//  mon_en=0: vld0/vld1 clear; no events; FIFO still drains; ts runs.
//  Detection, combinational, only when vld0&vld1:
//  - wrap_up = prev_q==max & cur_q==0.
//  - wrap_dn = prev_q==0 & cur_q==max.
//  - match   = cur_q==threshold & prev_q!=threshold.
//  - Several flags may be set in one record (e.g. threshold=0 with wrap_up).
//  - Any flag set -> push {flags,cur_q,ts} on next edge.
//  - First two samples after reset or re-enable never produce events.
//  Latency:
//  - count_in valid before edge k -> cur_q at k -> detection -> FIFO write at edge k+1.
//  - ev_valid high after k+1 if FIFO was empty (2 cycles).
//  Stream handshake:
//  - Pop when ev_valid&ev_ready.
//  - ev_data stable while ev_valid&!ev_ready.
//  - ev_data = FIFO head; no combinational path ev_ready->ev_valid.
//  FIFO push/pop rules:
//  - Push and pop same cycle: both occur, level unchanged; allowed when full.
//  - Push with full and no pop: record dropped; drop_cnt+1, saturating 0xFF.
//  - Pop with empty: ignored.
//  - ev_level and drop_cnt are registered.
//  - drop_cnt cleared only by reset.
//  Reset mid-operation: FIFO contents discarded immediately; no partial record emitted.
// CONFIGURATION
//  COUNT_MON_IRQ_EN defined:
//  - irq registered; 1 in the cycle after ev_level>=IRQ_LEVEL becomes true.
//  - Clears in the cycle after level drops below.
//  COUNT_MON_IRQ_EN undefined:
//  - irq tied 0; threshold logic for irq not built.
//  - Port list is unchanged.
// TESTING
//  1 Reset: aresetn=0 for 10 cycles, count_in toggling -> all outputs 0, ev_valid=0.
//  2 Wrap-up, ev_ready=1, threshold=0x80: count_in 0xFE,0xFF,0x00 -> one record.
//    Record: flags=010, count=0x00, ev_valid 2 cycles after 0x00 applied.
//  3 Wrap-down, threshold=0x00: count_in 0x01,0x00,0xFF.
//    Records: {100,0x00} for the match on 0x00, then {001,0xFF}.
//    Timestamps differ by 1.
//  4 Full/drop, DEPTH=4, ev_ready=0: 6 matches (threshold alternated).
//    Result: ev_level=4, drop_cnt=2.
//    Then ev_ready=1: 4 records in order, ev_level->0.
//  5 Enable gap: mon_en=0 while count goes 0xFF->0x00 -> no record.
//    Re-enable on 0x00 -> no record for the next 2 samples.
//  6 IRQ, COUNT_MON_IRQ_EN, IRQ_LEVEL=2: two events pending -> irq=1.
//    One pop -> irq=0 next cycle.
//    Build without macro -> irq stays 0 throughout.

Source files
------------

// File: rtl/count_event_monitor.sv
// count_event_monitor
//   Watches the counter IP's count_out bus, detects wrap-up, wrap-down and
//   threshold-match events, and queues timestamped records in a small FIFO
//   drained over a valid/ready stream.
//   Record layout: {match, wrap_up, wrap_dn, count, timestamp}.
//   Optional feature macro: COUNT_MON_IRQ_EN builds the registered
//   occupancy interrupt. Without it, irq is tied low and the port list is
//   unchanged.
module count_event_monitor #(
    parameter int CNT_W     = 8,
    parameter int TS_W      = 16,
    parameter int DEPTH     = 4,
    parameter int IRQ_LEVEL = 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [CNT_W-1:0]          count_in,
    input  logic                      mon_en,
    input  logic [CNT_W-1:0]          threshold,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [3+CNT_W+TS_W-1:0]   ev_data,
    output logic [$clog2(DEPTH):0]    ev_level,
    output logic [7:0]                drop_cnt,
    output logic                      irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = 3 + CNT_W + TS_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    // Elaboration-time parameter sanity: FIFO depth and irq threshold range.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_params
        $error("count_event_monitor: DEPTH must be a power of 2 >= 2 and IRQ_LEVEL in 1..DEPTH");
    end

    logic [TS_W-1:0]  ts_q;
    logic [CNT_W-1:0] cur_q;
    logic [CNT_W-1:0] prev_q;
    logic             vld0_q;
    logic             vld1_q;
    logic [REC_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [7:0]       drop_q, drop_d;

    logic             wrap_up_s;
    logic             wrap_dn_s;
    logic             match_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             wr_s;
    logic             drop_s;
    logic [REC_W-1:0] rec_s;

    // Free-running timestamp, independent of mon_en.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ts_q <= {TS_W{1'b0}};
        end else begin
            ts_q <= ts_q + {{(TS_W-1){1'b0}}, 1'b1};
        end
    end

    // Sample the count while enabled; sample-valid pipeline drops on disable.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cur_q  <= {CNT_W{1'b0}};
            prev_q <= {CNT_W{1'b0}};
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
        end else if (mon_en) begin
            cur_q  <= count_in;
            prev_q <= cur_q;
            vld0_q <= 1'b1;
            vld1_q <= vld0_q;
        end else begin
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
        end
    end

    // Event detection on the last two samples; suppressed while disabled.
    always_comb begin
        wrap_up_s = 1'b0;
        wrap_dn_s = 1'b0;
        match_s   = 1'b0;
        if (vld0_q && vld1_q && mon_en) begin
            wrap_up_s = (prev_q == CNT_MAX)  && (cur_q == CNT_ZERO);
            wrap_dn_s = (prev_q == CNT_ZERO) && (cur_q == CNT_MAX);
            match_s   = (cur_q == threshold) && (prev_q != threshold);
        end else begin
            wrap_up_s = 1'b0;
            wrap_dn_s = 1'b0;
            match_s   = 1'b0;
        end
        push_s = match_s | wrap_up_s | wrap_dn_s;
        rec_s  = {match_s, wrap_up_s, wrap_dn_s, cur_q, ts_q};
    end

    // FIFO control: simultaneous push/pop is legal even when full.
    always_comb begin
        full_s   = (level_q == LVL_FULL);
        pop_s    = (level_q != {LVL_W{1'b0}}) && ev_ready;
        wr_s     = push_s && (!full_s || pop_s);
        drop_s   = push_s && full_s && !pop_s;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        level_d = level_q + {{(LVL_W-1){1'b0}}, wr_s} - {{(LVL_W-1){1'b0}}, pop_s};
        if (drop_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // FIFO state registers; reset discards any queued records.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
            drop_q   <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    // FIFO storage, cleared on reset so the head reads zero afterwards.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {REC_W{1'b0}};
            end
        end else if (wr_s) begin
            mem_q[wr_ptr_q] <= rec_s;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign ev_valid = (level_q != {LVL_W{1'b0}});
    assign ev_data  = mem_q[rd_ptr_q];
    assign ev_level = level_q;
    assign drop_cnt = drop_q;

`ifdef COUNT_MON_IRQ_EN
    localparam logic [LVL_W-1:0] IRQ_LVL = LVL_W'(IRQ_LEVEL);
    logic irq_q, irq_d;

    // Interrupt request follows the registered occupancy one cycle later.
    always_comb begin
        irq_d = (level_q >= IRQ_LVL);
    end

    // Interrupt register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_count_event_monitor.sv
// Self-checking bench for count_event_monitor: directed scenarios plus
// randomized traffic, compared every cycle against a queue-based model.
module tb_count_event_monitor;

    localparam int CNT_W     = 8;
    localparam int TS_W      = 16;
    localparam int DEPTH     = 4;
    localparam int IRQ_LEVEL = 2;
    localparam int LVL_W     = 3;
    localparam int REC_W     = 3 + CNT_W + TS_W;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [CNT_W-1:0] count_in = 8'h00;
    logic             mon_en = 1'b0;
    logic [CNT_W-1:0] threshold = 8'h00;
    logic             ev_valid;
    logic             ev_ready = 1'b0;
    logic [REC_W-1:0] ev_data;
    logic [LVL_W-1:0] ev_level;
    logic [7:0]       drop_cnt;
    logic             irq;

    count_event_monitor #(
        .CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LEVEL)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .count_in(count_in), .mon_en(mon_en),
        .threshold(threshold), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_data(ev_data), .ev_level(ev_level), .drop_cnt(drop_cnt), .irq(irq)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [REC_W-1:0] m_q[$];
    int               m_drop;
    logic [TS_W-1:0]  m_ts;
    int               m_nsamp;
    logic [CNT_W-1:0] m_cur, m_prev;
    logic             m_irq;

    task automatic model_reset();
        m_q.delete();
        m_drop  = 0;
        m_ts    = 16'h0000;
        m_nsamp = 0;
        m_cur   = 8'h00;
        m_prev  = 8'h00;
        m_irq   = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs presently driven.
    task automatic model_step();
        int       size_pre;
        bit       popped;
        logic [2:0] fl;
        if (!aresetn) begin
            model_reset();
        end else begin
            size_pre = m_q.size();
`ifdef COUNT_MON_IRQ_EN
            m_irq = (size_pre >= IRQ_LEVEL);
`else
            m_irq = 1'b0;
`endif
            fl = 3'b000;
            if (mon_en && m_nsamp >= 2) begin
                if (m_prev == 8'hFF && m_cur == 8'h00) fl[1] = 1'b1;
                if (m_prev == 8'h00 && m_cur == 8'hFF) fl[0] = 1'b1;
                if (m_cur == threshold && m_prev != threshold) fl[2] = 1'b1;
            end
            popped = 0;
            if (size_pre > 0 && ev_ready) begin
                void'(m_q.pop_front());
                popped = 1;
            end
            if (fl != 3'b000) begin
                if (size_pre < DEPTH || popped) m_q.push_back({fl, m_cur, m_ts});
                else if (m_drop < 255) m_drop++;
            end
            if (mon_en) begin
                m_prev = m_cur;
                m_cur  = count_in;
                if (m_nsamp < 2) m_nsamp++;
            end else begin
                m_nsamp = 0;
            end
            m_ts = m_ts + 16'd1;
        end
    endtask

    task automatic check_all();
        check_val("ev_valid", {63'd0, ev_valid}, {63'd0, (m_q.size() != 0)});
        check_val("ev_level", {61'd0, ev_level}, 64'(m_q.size()));
        check_val("drop_cnt", {56'd0, drop_cnt}, 64'(m_drop));
        check_val("irq", {63'd0, irq}, {63'd0, m_irq});
        if (m_q.size() != 0) check_val("ev_data", {37'd0, ev_data}, {37'd0, m_q[0]});
    endtask

    task automatic step();
        model_step();
        @(posedge aclk);
        @(negedge aclk);
        check_all();
    endtask

    task automatic drive(input logic [7:0] c, input logic en, input logic [7:0] th, input logic rdy);
        count_in  = c;
        mon_en    = en;
        threshold = th;
        ev_ready  = rdy;
        step();
    endtask

    task automatic do_reset(input int cycles);
        aresetn = 1'b0;
        #1;
        check_val("rst_ev_valid", {63'd0, ev_valid}, 64'd0);
        check_val("rst_ev_level", {61'd0, ev_level}, 64'd0);
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            count_in = 8'($urandom);
            step();
        end
        aresetn = 1'b1;
    endtask

    logic [7:0] rnd_thr;
    int         r;

    initial begin
        model_reset();
        // 1: reset held 10 cycles with count toggling
        @(negedge aclk);
        for (int i = 0; i < 10; i++) begin
            count_in = (i % 2 == 0) ? 8'hA5 : 8'h5A;
            step();
            check_val("rst_ev_data", {37'd0, ev_data}, 64'd0);
            check_val("rst_drop", {56'd0, drop_cnt}, 64'd0);
        end
        aresetn = 1'b1;

        // 2: wrap-up
        drive(8'hFE, 1'b1, 8'h80, 1'b1);
        drive(8'hFF, 1'b1, 8'h80, 1'b1);
        drive(8'h00, 1'b1, 8'h80, 1'b1);
        check_val("t2_not_yet", {63'd0, ev_valid}, 64'd0);
        drive(8'h00, 1'b1, 8'h80, 1'b1);
        check_val("t2_valid", {63'd0, ev_valid}, 64'd1);
        check_val("t2_flags", {61'd0, ev_data[REC_W-1 -: 3]}, 64'b010);
        check_val("t2_count", {56'd0, ev_data[TS_W +: CNT_W]}, 64'h00);
        drive(8'h00, 1'b1, 8'h80, 1'b1);
        check_val("t2_drained", {63'd0, ev_valid}, 64'd0);

        // 3: wrap-down with threshold 0, consumer stalled
        drive(8'h01, 1'b1, 8'h00, 1'b0);
        drive(8'h00, 1'b1, 8'h00, 1'b0);
        drive(8'hFF, 1'b1, 8'h00, 1'b0);
        drive(8'hFF, 1'b1, 8'h00, 1'b0);
        drive(8'hFF, 1'b1, 8'h00, 1'b0);
        check_val("t3_level", {61'd0, ev_level}, 64'd2);
        check_val("t3_first", {61'd0, ev_data[REC_W-1 -: 3]}, 64'b100);

        // reset mid-operation discards queued records
        do_reset(3);

        // 4: full/drop, 6 matches with consumer stalled
        for (int i = 0; i < 13; i++) drive((i % 2 == 0) ? 8'h20 : 8'h10, 1'b1, 8'h10, 1'b0);
        drive(8'h20, 1'b0, 8'h10, 1'b0);
        check_val("t4_level", {61'd0, ev_level}, 64'd4);
        check_val("t4_drop", {56'd0, drop_cnt}, 64'd2);
        for (int i = 0; i < 5; i++) drive(8'h20, 1'b0, 8'h10, 1'b1);
        check_val("t4_empty", {61'd0, ev_level}, 64'd0);

        // 5: enable gap across a wrap, re-enable on 0x00
        drive(8'hFE, 1'b1, 8'h80, 1'b1);
        drive(8'hFF, 1'b1, 8'h80, 1'b1);
        drive(8'hFF, 1'b0, 8'h80, 1'b1);
        drive(8'h00, 1'b0, 8'h80, 1'b1);
        drive(8'h00, 1'b1, 8'h80, 1'b1);
        drive(8'h00, 1'b1, 8'h80, 1'b1);
        drive(8'h00, 1'b1, 8'h80, 1'b1);
        check_val("t5_no_event", {61'd0, ev_level}, 64'd0);

        // 6: interrupt on two pending events
        do_reset(2);
        for (int i = 0; i < 5; i++) drive((i % 2 == 0) ? 8'h20 : 8'h10, 1'b1, 8'h10, 1'b0);
        drive(8'h20, 1'b0, 8'h10, 1'b0);
        drive(8'h20, 1'b0, 8'h10, 1'b0);
        check_val("t6_level", {61'd0, ev_level}, 64'd2);
`ifdef COUNT_MON_IRQ_EN
        check_val("t6_irq_set", {63'd0, irq}, 64'd1);
`else
        check_val("t6_irq_off", {63'd0, irq}, 64'd0);
`endif
        drive(8'h20, 1'b0, 8'h10, 1'b1);
        drive(8'h20, 1'b0, 8'h10, 1'b0);
        check_val("t6_irq_clear", {63'd0, irq}, 64'd0);

        // drop counter saturation
        do_reset(2);
        for (int i = 0; i < 540; i++) drive((i % 2 == 0) ? 8'h20 : 8'h10, 1'b1, 8'h10, 1'b0);
        check_val("drop_sat", {56'd0, drop_cnt}, 64'hFF);

        // randomized traffic with occasional resets
        do_reset(2);
        rnd_thr = 8'h40;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                r = $urandom_range(0, 2);
                rnd_thr = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            end
            r = $urandom_range(0, 9);
            count_in  = (r < 3) ? 8'h00 : (r < 5) ? 8'hFF : (r < 7) ? rnd_thr : 8'($urandom);
            mon_en    = ($urandom_range(0, 15) != 0);
            threshold = rnd_thr;
            ev_ready  = ((i / 64) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (i == 700) begin
                do_reset(2);
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
